out_tile_sched: RTL and testbench

Write-port scheduler between the four MAC-array output rows and the single output-memory write port. Each row hands over one completed 64-bit row word with a 4-bit tile-relative destination. The block buffers one word per row and serializes the words onto OMEM with round-robin arbitration and a ready/valid handshake. It also sequences tiles: it arms on `Start`, counts the NROW row writes, then pulses `Tile_Done`. Simultaneous row completions therefore never collide on the write port.

---
 rtl/macarray_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/out_tile_sched.sv | 146 ++++++++++++++
 tb/tb_out_tile_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macarray_pkg.sv
// Shared definitions for the MAC-array output path: default geometry and
// the tile sequencing state encoding.
package macarray_pkg;

   localparam int DEF_NROW = 4;
   localparam int DEF_DW   = 64;
   localparam int DEF_RAW  = 4;
   localparam int DEF_OAW  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tile_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
// NROW must be a power of two so the search index wraps naturally.
module rr_arbiter #(
   parameter  int NROW = 4,
   localparam int PW   = $clog2(NROW)
) (
   input  logic [NROW-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NROW-1:0] gnt,
   output logic            gnt_vld
);

   logic [PW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int k = 0; k < NROW; k++) begin
         idx = ptr + PW'(k);
         if (!gnt_vld && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/out_tile_sched.sv
// Buffers one word per MAC output row and serialises them onto the single
// OMEM write port with round-robin arbitration, sequencing one tile per Start.
module out_tile_sched
   import macarray_pkg::*;
#(
   parameter int NROW = DEF_NROW,
   parameter int DW   = DEF_DW,
   parameter int RAW  = DEF_RAW,
   parameter int OAW  = DEF_OAW
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              Start,
   input  logic [OAW-1:0]    Tile_Base,
   input  logic [NROW-1:0]   Row_Valid,
   input  logic [NROW*DW-1:0]  Row_Data,
   input  logic [NROW*RAW-1:0] Row_Addr,
   output logic [NROW-1:0]   Row_Ready,
   output logic              OMEM_Write,
   input  logic              OMEM_Ready,
   output logic [DW-1:0]     OMEM_Data,
   output logic [OAW-1:0]    OMEM_Addr,
   output logic              Tile_Done,
   output logic              Busy,
   output logic [7:0]        Tile_Cnt,
   output logic              Err_Dup
);

   localparam int PTR_W = $clog2(NROW);

   tile_state_e      state_q, state_d;
   logic [PTR_W-1:0] rr_ptr;
   logic [NROW-1:0]  slot_full, written;
   logic [DW-1:0]    slot_data [NROW];
   logic [RAW-1:0]   slot_addr [NROW];
   logic [OAW-1:0]   base_q;
   logic [PTR_W:0]   wr_cnt;
   logic [7:0]       tile_cnt;
   logic             err_dup;

   logic             omem_vld_p0;
   logic [DW-1:0]    omem_data_p0;
   logic [OAW-1:0]   omem_addr_p0;

   logic             run, hs, load_en, take, last_wr, arm;
   logic [NROW-1:0]  accept, dup, gnt_oh;
   logic             gnt_vld;
   logic [PTR_W-1:0] gnt_idx;
   logic [OAW-1:0]   wr_addr_nxt;

   assign run       = (state_q == RUN);
   assign arm       = (state_q == IDLE) && Start;
   assign Row_Ready = {NROW{run}} & ~slot_full & ~written;
   assign accept    = Row_Valid & Row_Ready;
   assign dup       = {NROW{run}} & Row_Valid & written;
   assign hs        = omem_vld_p0 & OMEM_Ready;
   // The output register may reload whenever it is empty or draining this edge.
   assign load_en   = run & (~omem_vld_p0 | OMEM_Ready);
   assign take      = load_en & gnt_vld;
   assign last_wr   = hs && (wr_cnt == (PTR_W+1)'(NROW-1));

   rr_arbiter #(.NROW(NROW)) u_arb (
      .req     (slot_full),
      .ptr     (rr_ptr),
      .gnt     (gnt_oh),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NROW; i++)
         if (gnt_oh[i]) gnt_idx = PTR_W'(i);
   end

   assign wr_addr_nxt = base_q + {{(OAW-RAW){1'b0}}, slot_addr[gnt_idx]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Start) state_d = RUN;
         RUN:     if (last_wr) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state, counters and the OMEM output register
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q      <= IDLE;
         rr_ptr       <= '0;
         slot_full    <= '0;
         written      <= '0;
         wr_cnt       <= '0;
         base_q       <= '0;
         tile_cnt     <= '0;
         err_dup      <= 1'b0;
         omem_vld_p0  <= 1'b0;
         omem_data_p0 <= '0;
         omem_addr_p0 <= '0;
      end else begin
         state_q <= state_d;
         if (arm) begin
            base_q    <= Tile_Base;
            slot_full <= '0;
            written   <= '0;
            wr_cnt    <= '0;
         end else begin
            slot_full <= (slot_full | accept) & ~(take ? gnt_oh : '0);
            if (take) begin
               written <= written | gnt_oh;
               rr_ptr  <= gnt_idx + PTR_W'(1);
            end
            if (hs) wr_cnt <= wr_cnt + 1'b1;
         end
         if (|dup)    err_dup  <= 1'b1;
         if (last_wr) tile_cnt <= tile_cnt + 8'd1;
         if (take) begin
            omem_vld_p0  <= 1'b1;
            omem_data_p0 <= slot_data[gnt_idx];
            omem_addr_p0 <= wr_addr_nxt;
         end else if (hs) begin
            omem_vld_p0  <= 1'b0;
         end
      end
   end

   // Slot payload capture; validity is tracked by slot_full
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NROW; i++) begin
         if (accept[i]) begin
            slot_data[i] <= Row_Data[i*DW +: DW];
            slot_addr[i] <= Row_Addr[i*RAW +: RAW];
         end
      end
   end

   assign OMEM_Write = omem_vld_p0;
   assign OMEM_Data  = omem_data_p0;
   assign OMEM_Addr  = omem_addr_p0;
   assign Tile_Done  = (state_q == DONE);
   assign Busy       = (state_q != IDLE);
   assign Tile_Cnt   = tile_cnt;
   assign Err_Dup    = err_dup;

endmodule

// File: tb/tb_out_tile_sched.sv
// Directed bench for out_tile_sched: single-row tiles, collisions, backpressure,
// address wrap, round-robin order, duplicate offers and mid-tile reset.
module tb_out_tile_sched;

   logic          CLK;
   logic          RSTN;
   logic          Start;
   logic [7:0]    Tile_Base;
   logic [3:0]    Row_Valid;
   logic [255:0]  Row_Data;
   logic [15:0]   Row_Addr;
   logic [3:0]    Row_Ready;
   logic          OMEM_Write;
   logic          OMEM_Ready;
   logic [63:0]   OMEM_Data;
   logic [7:0]    OMEM_Addr;
   logic          Tile_Done;
   logic          Busy;
   logic [7:0]    Tile_Cnt;
   logic          Err_Dup;

   int            n_chk;
   int            n_fail;
   int            cyc;
   int            done_cnt;
   int            done_cyc;
   logic [63:0]   wq_data [$];
   logic [7:0]    wq_addr [$];
   int            wq_cyc  [$];

   out_tile_sched dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .Start      (Start),
      .Tile_Base  (Tile_Base),
      .Row_Valid  (Row_Valid),
      .Row_Data   (Row_Data),
      .Row_Addr   (Row_Addr),
      .Row_Ready  (Row_Ready),
      .OMEM_Write (OMEM_Write),
      .OMEM_Ready (OMEM_Ready),
      .OMEM_Data  (OMEM_Data),
      .OMEM_Addr  (OMEM_Addr),
      .Tile_Done  (Tile_Done),
      .Busy       (Busy),
      .Tile_Cnt   (Tile_Cnt),
      .Err_Dup    (Err_Dup)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) begin
      if (RSTN && OMEM_Write && OMEM_Ready) begin
         wq_data.push_back(OMEM_Data);
         wq_addr.push_back(OMEM_Addr);
         wq_cyc.push_back(cyc);
      end
      if (RSTN && Tile_Done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_row(input int i, input logic [63:0] d, input logic [3:0] a);
      Row_Data[i*64 +: 64] = d;
      Row_Addr[i*4 +: 4]   = a;
   endtask

   task automatic offer(input logic [3:0] m);
      Row_Valid = m;
      tick();
      Row_Valid = 4'b0;
   endtask

   task automatic start_tile(input logic [7:0] b);
      Start     = 1'b1;
      Tile_Base = b;
      tick();
      Start     = 1'b0;
   endtask

   task automatic clear_log();
      wq_data.delete();
      wq_addr.delete();
      wq_cyc.delete();
      done_cnt = 0;
      done_cyc = 0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (Tile_Done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check_eq({tag, "_done"}, 64'(Tile_Done), 64'd1);
   endtask

   task automatic check_writes(input string tag, input int n,
                               input logic [63:0] ed [4], input logic [7:0] ea [4]);
      check_eq({tag, "_nwr"}, 64'(wq_data.size()), 64'(n));
      for (int k = 0; k < n; k++) begin
         if (k < wq_data.size()) begin
            check_eq($sformatf("%s_data%0d", tag, k), wq_data[k], ed[k]);
            check_eq($sformatf("%s_addr%0d", tag, k), 64'(wq_addr[k]), 64'(ea[k]));
         end
      end
   endtask

   initial begin
      logic [63:0] ed [4];
      logic [7:0]  ea [4];
      int          ord [4];

      n_chk = 0; n_fail = 0; done_cnt = 0; done_cyc = 0;
      RSTN = 1'b0; Start = 1'b0; Tile_Base = 8'h0; Row_Valid = 4'b0;
      Row_Data = '0; Row_Addr = '0; OMEM_Ready = 1'b1;
      tick(); tick();

      check_eq("rst_write",  64'(OMEM_Write), 64'd0);
      check_eq("rst_data",   OMEM_Data,       64'd0);
      check_eq("rst_addr",   64'(OMEM_Addr),  64'd0);
      check_eq("rst_busy",   64'(Busy),       64'd0);
      check_eq("rst_done",   64'(Tile_Done),  64'd0);
      check_eq("rst_cnt",    64'(Tile_Cnt),   64'd0);
      check_eq("rst_err",    64'(Err_Dup),    64'd0);
      check_eq("rst_ready",  64'(Row_Ready),  64'd0);
      RSTN = 1'b1;
      tick();

      // Single rows offered one at a time
      clear_log();
      for (int i = 0; i < 4; i++) set_row(i, 64'hA000_0000_0000_0000 | 64'(i), 4'(i));
      start_tile(8'h40);
      check_eq("t1_busy",  64'(Busy),      64'd1);
      check_eq("t1_ready", 64'(Row_Ready), 64'hF);
      for (int i = 0; i < 4; i++) begin
         offer(4'(1 << i));
         if (i < 3) begin tick(); tick(); tick(); end
      end
      wait_done("t1", 20);
      check_eq("t1_tilecnt", 64'(Tile_Cnt), 64'd1);
      tick();
      check_eq("t1_idle",  64'(Busy), 64'd0);
      check_eq("t1_npulse", 64'(done_cnt), 64'd1);
      ed = '{64'hA000_0000_0000_0000, 64'hA000_0000_0000_0001,
             64'hA000_0000_0000_0002, 64'hA000_0000_0000_0003};
      ea = '{8'h40, 8'h41, 8'h42, 8'h43};
      check_writes("t1", 4, ed, ea);

      // All four rows complete together
      clear_log();
      for (int i = 0; i < 4; i++) set_row(i, 64'h1111_1111_1111_1111 * 64'(i + 1), 4'(i));
      start_tile(8'h80);
      offer(4'hF);
      check_eq("t2_lat0", 64'(OMEM_Write), 64'd0);
      tick();
      check_eq("t2_lat1",   64'(OMEM_Write), 64'd1);
      check_eq("t2_first",  OMEM_Data,       64'h1111_1111_1111_1111);
      check_eq("t2_faddr",  64'(OMEM_Addr),  64'h80);
      wait_done("t2", 20);
      check_eq("t2_tilecnt", 64'(Tile_Cnt), 64'd2);
      tick();
      ed = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      ea = '{8'h80, 8'h81, 8'h82, 8'h83};
      check_writes("t2", 4, ed, ea);
      if (wq_cyc.size() == 4) begin
         for (int k = 1; k < 4; k++)
            check_eq($sformatf("t2_b2b%0d", k), 64'(wq_cyc[k]), 64'(wq_cyc[0] + k));
         check_eq("t2_donecyc", 64'(done_cyc), 64'(wq_cyc[3] + 1));
      end

      // Backpressure during the second write
      clear_log();
      for (int i = 0; i < 4; i++) set_row(i, 64'hC0DE_0000_0000_0000 | 64'(i), 4'(i));
      start_tile(8'h10);
      offer(4'hF);
      tick();
      tick();
      OMEM_Ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check_eq($sformatf("t3_hold_w%0d", j), 64'(OMEM_Write), 64'd1);
         check_eq($sformatf("t3_hold_d%0d", j), OMEM_Data,       64'hC0DE_0000_0000_0001);
         check_eq($sformatf("t3_hold_a%0d", j), 64'(OMEM_Addr),  64'h11);
      end
      OMEM_Ready = 1'b1;
      wait_done("t3", 20);
      check_eq("t3_tilecnt", 64'(Tile_Cnt), 64'd3);
      tick();
      ed = '{64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001,
             64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0003};
      ea = '{8'h10, 8'h11, 8'h12, 8'h13};
      check_writes("t3", 4, ed, ea);

      // Address wrap; offer order 0,2,3,1 leaves the pointer at row 2
      clear_log();
      for (int i = 0; i < 4; i++) set_row(i, 64'hD000_0000_0000_0000 | 64'(i), 4'(i));
      start_tile(8'hFE);
      ord = '{0, 2, 3, 1};
      for (int j = 0; j < 4; j++) begin
         offer(4'(1 << ord[j]));
         if (j < 3) begin tick(); tick(); tick(); end
      end
      wait_done("t4a", 20);
      check_eq("t4a_tilecnt", 64'(Tile_Cnt), 64'd4);
      tick();
      ed = '{64'hD000_0000_0000_0000, 64'hD000_0000_0000_0002,
             64'hD000_0000_0000_0003, 64'hD000_0000_0000_0001};
      ea = '{8'hFE, 8'h00, 8'h01, 8'hFF};
      check_writes("t4a", 4, ed, ea);

      // Rows 1 and 3 pending with pointer at 2: row 3 first
      clear_log();
      for (int i = 0; i < 4; i++) set_row(i, 64'hE000_0000_0000_0000 | 64'(i), 4'(i));
      start_tile(8'h20);
      offer(4'b1010);
      tick(); tick(); tick();
      offer(4'b0101);
      wait_done("t4b", 20);
      check_eq("t4b_tilecnt", 64'(Tile_Cnt), 64'd5);
      tick();
      ed = '{64'hE000_0000_0000_0003, 64'hE000_0000_0000_0001,
             64'hE000_0000_0000_0002, 64'hE000_0000_0000_0000};
      ea = '{8'h23, 8'h21, 8'h22, 8'h20};
      check_writes("t4b", 4, ed, ea);

      // Duplicate offer of row 2 is dropped and flagged
      clear_log();
      for (int i = 0; i < 4; i++) set_row(i, 64'hF000_0000_0000_0000 | 64'(i), 4'(i));
      start_tile(8'h30);
      check_eq("t5_err0", 64'(Err_Dup), 64'd0);
      offer(4'b0100);
      tick(); tick(); tick();
      check_eq("t5_ready", 64'(Row_Ready), 64'b1011);
      set_row(2, 64'hBAD0_BAD0_BAD0_BAD0, 4'd9);
      offer(4'b0100);
      check_eq("t5_err1", 64'(Err_Dup), 64'd1);
      offer(4'b1011);
      wait_done("t5", 20);
      check_eq("t5_tilecnt", 64'(Tile_Cnt), 64'd6);
      tick();
      check_eq("t5_sticky", 64'(Err_Dup), 64'd1);
      ed = '{64'hF000_0000_0000_0002, 64'hF000_0000_0000_0003,
             64'hF000_0000_0000_0000, 64'hF000_0000_0000_0001};
      ea = '{8'h32, 8'h33, 8'h30, 8'h31};
      check_writes("t5", 4, ed, ea);

      // Reset in the middle of a tile with a write pending
      for (int i = 0; i < 4; i++) set_row(i, 64'h6000_0000_0000_0000 | 64'(i), 4'(i));
      start_tile(8'h50);
      offer(4'hF);
      OMEM_Ready = 1'b0;
      tick();
      check_eq("t6_pending", 64'(OMEM_Write), 64'd1);
      RSTN = 1'b0;
      tick();
      check_eq("t6_write", 64'(OMEM_Write), 64'd0);
      check_eq("t6_data",  OMEM_Data,       64'd0);
      check_eq("t6_addr",  64'(OMEM_Addr),  64'd0);
      check_eq("t6_busy",  64'(Busy),       64'd0);
      check_eq("t6_done",  64'(Tile_Done),  64'd0);
      check_eq("t6_cnt",   64'(Tile_Cnt),   64'd0);
      check_eq("t6_err",   64'(Err_Dup),    64'd0);
      check_eq("t6_ready", 64'(Row_Ready),  64'd0);
      RSTN = 1'b1;
      OMEM_Ready = 1'b1;
      clear_log();
      offer(4'hF);
      repeat (8) tick();
      check_eq("t6_nowr",   64'(wq_data.size()), 64'd0);
      check_eq("t6_idlewr", 64'(OMEM_Write),     64'd0);
      check_eq("t6_noerr",  64'(Err_Dup),        64'd0);
      start_tile(8'h60);
      offer(4'b0001);
      tick();
      check_eq("t6_newwr",   64'(OMEM_Write), 64'd1);
      check_eq("t6_newdata", OMEM_Data,       64'h6000_0000_0000_0000);
      check_eq("t6_newaddr", 64'(OMEM_Addr),  64'h60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
